// File: rtl/mac_accum_8.sv
// mac_accum_8: signed dot-product accumulator with valid/ready on both sides and saturated 8-bit rescale
module mac_accum_8 #(
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 8,
  parameter int MAX_LEN   = 64
) (
  input  logic                           I_CLK,
  input  logic                           I_RST,
  input  logic [15:0]                    I_PROD,
  input  logic                           I_VALID,
  input  logic                           I_LAST,
  output logic                           O_READY,
  output logic                           O_VALID,
  input  logic                           I_READY,
  output logic [ACC_W-1:0]               O_SUM_ACC,
  output logic [7:0]                     O_SUM_8,
  output logic                           O_CLIP,
  output logic [$clog2(MAX_LEN+1)-1:0]   O_CNT,
  output logic                           O_LEN_ERR
);
  localparam int CNT_W = $clog2(MAX_LEN+1);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               len_err_q, len_err_d;
  logic               accept, term, hs;
  logic [CNT_W-1:0]   cnt_nx;
  logic signed [ACC_W-1:0] sh;
  logic               ovf;
  assign O_READY = (state_q != OUT) && !I_RST;
  assign accept  = I_VALID && O_READY;
  assign cnt_nx  = cnt_q + 1'b1;
  assign term    = accept && (I_LAST || cnt_nx == CNT_W'(MAX_LEN));
  assign hs      = (state_q == OUT) && I_READY;
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end
  always_comb begin
    state_d = (state_q == OUT) ? (I_READY ? IDLE : OUT) :
              accept ? (term ? OUT : ACC) : state_q;
  end
  always_comb begin
    acc_d     = hs ? '0 : accept ? acc_q + {{(ACC_W-16){I_PROD[15]}}, I_PROD} : acc_q;
    cnt_d     = hs ? '0 : accept ? cnt_nx : cnt_q;
    len_err_d = hs ? 1'b0 : term ? !I_LAST : len_err_q;
  end
  // Saturate when the shifted value's bits above bit 7 are not a pure sign extension
  always_comb begin
    sh        = $signed(acc_q) >>> OUT_SHIFT;
    ovf       = !((&sh[ACC_W-1:7]) || !(|sh[ACC_W-1:7]));
    O_VALID   = state_q == OUT;
    O_SUM_ACC = acc_q;
    O_CNT     = cnt_q;
    O_LEN_ERR = len_err_q;
    O_CLIP    = ovf;
    O_SUM_8   = ovf ? (sh[ACC_W-1] ? 8'h80 : 8'h7F) : sh[7:0];
  end
endmodule

// File: tb/tb_mac_accum_8.sv
// tb_mac_accum_8: table-driven vectors plus directed reset, backpressure and max-length sequences
module tb_mac_accum_8;
  logic        I_CLK = 0, I_RST, I_VALID, I_LAST, I_READY, O_READY, O_VALID, O_CLIP, O_LEN_ERR;
  logic [15:0] I_PROD;
  logic [23:0] O_SUM_ACC;
  logic [7:0]  O_SUM_8;
  logic [6:0]  O_CNT;
  int errs = 0, checks = 0;
  typedef struct {
    int n;
    logic [3:0][15:0] p;
    int acc, s8, clip, cnt;
  } vec_t;
  vec_t tbl[9];
  mac_accum_8 dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_PROD(I_PROD), .I_VALID(I_VALID), .I_LAST(I_LAST),
    .O_READY(O_READY), .O_VALID(O_VALID), .I_READY(I_READY), .O_SUM_ACC(O_SUM_ACC),
    .O_SUM_8(O_SUM_8), .O_CLIP(O_CLIP), .O_CNT(O_CNT), .O_LEN_ERR(O_LEN_ERR)
  );
  always #5 I_CLK = ~I_CLK;
  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang required finish");
    $fatal(1);
  end
  function automatic vec_t mk(int n, logic [15:0] a, b, c, d, int acc, s8, clip, cnt);
    vec_t v;
    v.n = n; v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.acc = acc; v.s8 = s8; v.clip = clip; v.cnt = cnt;
    return v;
  endfunction
  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_out(input int v, input int acc, input int s8, input int clip, input int cnt, input int lerr);
    chk("o_valid", O_VALID, v);
    chk("o_sum_acc", $signed(O_SUM_ACC), acc);
    chk("o_sum_8", $signed(O_SUM_8), s8);
    chk("o_clip", O_CLIP, clip);
    chk("o_cnt", O_CNT, cnt);
    chk("o_len_err", O_LEN_ERR, lerr);
  endtask
  task automatic beat(input logic [15:0] p, input logic last);
    int w = 0;
    I_VALID = 1; I_PROD = p; I_LAST = last;
    while (!O_READY && w < 10) begin
      @(negedge I_CLK);
      w++;
    end
    chk("beat_ready", O_READY, 1);
    @(negedge I_CLK);
    I_VALID = 0; I_LAST = 0;
  endtask
  task automatic handshake();
    I_VALID = 1; I_READY = 1; I_PROD = 16'h5555; I_LAST = 0;
    @(negedge I_CLK);
    I_VALID = 0; I_READY = 0;
    chk("hs_ready", O_READY, 1);
    chk_out(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    tbl[0] = mk(3, 16'h0100, 16'h0200, 16'hFF00, 0, 512, 2, 0, 3);
    tbl[1] = mk(4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 131068, 127, 1, 4);
    tbl[2] = mk(4, 16'h8000, 16'h8000, 16'h8000, 16'h8000, -131072, -128, 1, 4);
    tbl[3] = mk(1, 16'hFFFF, 0, 0, 0, -1, -1, 0, 1);
    tbl[4] = mk(1, 16'h0100, 0, 0, 0, 256, 1, 0, 1);
    tbl[5] = mk(2, 16'h7F00, 16'h0000, 0, 0, 32512, 127, 0, 2);
    tbl[6] = mk(1, 16'h8000, 0, 0, 0, -32768, -128, 0, 1);
    tbl[7] = mk(2, 16'h7F80, 16'h0080, 0, 0, 32768, 127, 1, 2);
    tbl[8] = mk(1, 16'hFEFF, 0, 0, 0, -257, -2, 0, 1);
    I_RST = 1; I_VALID = 0; I_LAST = 0; I_READY = 0; I_PROD = 0;
    repeat (2) @(negedge I_CLK);
    chk("rst_ready_low", O_READY, 0);
    chk_out(0, 0, 0, 0, 0, 0);
    I_RST = 0;
    #1 chk("post_rst_ready", O_READY, 1);
    @(negedge I_CLK);
    for (int i = 0; i < 9; i++) begin
      for (int b = 0; b < tbl[i].n; b++) beat(tbl[i].p[b], b == tbl[i].n - 1);
      chk_out(1, tbl[i].acc, tbl[i].s8, tbl[i].clip, tbl[i].cnt, 0);
      chk("out_ready_low", O_READY, 0);
      handshake();
    end
    // reset mid-vector discards the partial sum
    beat(16'd100, 0); beat(16'd200, 0); beat(16'd300, 0);
    chk_out(0, 600, 2, 0, 3, 0);
    I_RST = 1;
    #1 chk("mid_rst_ready", O_READY, 0);
    @(negedge I_CLK);
    I_RST = 0;
    #1 chk("mid_rst_ready_after", O_READY, 1);
    chk_out(0, 0, 0, 0, 0, 0);
    @(negedge I_CLK);
    beat(16'h0100, 1);
    chk_out(1, 256, 1, 0, 1, 0);
    handshake();
    // backpressure with upstream still presenting beats
    beat(16'd10, 0); beat(16'd20, 1);
    I_VALID = 1; I_PROD = 16'd999;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", O_READY, 0);
      chk_out(1, 30, 0, 0, 2, 0);
      @(negedge I_CLK);
    end
    I_READY = 1;
    @(negedge I_CLK);
    I_VALID = 0; I_READY = 0;
    chk("bp_release_ready", O_READY, 1);
    chk_out(0, 0, 0, 0, 0, 0);
    // max length termination, beat 65 waits for the output handshake
    for (int b = 0; b < 64; b++) beat(16'd1, 0);
    chk_out(1, 64, 0, 0, 64, 1);
    I_VALID = 1; I_PROD = 16'd1; I_LAST = 1;
    for (int c = 0; c < 3; c++) begin
      chk("b65_ready", O_READY, 0);
      chk("b65_cnt", O_CNT, 64);
      @(negedge I_CLK);
    end
    I_READY = 1;
    @(negedge I_CLK);
    I_READY = 0;
    chk("b65_bubble_ready", O_READY, 1);
    chk_out(0, 0, 0, 0, 0, 0);
    @(negedge I_CLK);
    I_VALID = 0; I_LAST = 0;
    chk_out(1, 1, 0, 0, 1, 0);
    handshake();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
